// File: rtl/sd_spi_pkg.sv
// rtl/sd_spi_pkg.sv - shared types and SPI core register map for the SD SPI transfer sequencer
package sd_spi_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SS_ON,
        ST_GET_TX,
        ST_WR_TX,
        ST_POLL,
        ST_RD_RX,
        ST_PUT_RX,
        ST_ERR_CLR,
        ST_SS_OFF,
        ST_DONE
    } seq_state_e;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_ACC1,
        PH_ACC2,
        PH_GAP
    } bus_phase_e;

    localparam logic [2:0] REG_RXDATA  = 3'd0;
    localparam logic [2:0] REG_TXDATA  = 3'd1;
    localparam logic [2:0] REG_STATUS  = 3'd2;
    localparam logic [2:0] REG_CONTROL = 3'd3;

    localparam int STAT_RRDY = 8;
    localparam int STAT_TOE  = 5;
    localparam int STAT_ROE  = 4;

    localparam logic [15:0] CTRL_SSO = 16'h0400;

endpackage

// File: rtl/sd_spi_bus_access.sv
// rtl/sd_spi_bus_access.sv - one 2-cycle SPI core register access followed by an idle cycle
module sd_spi_bus_access
    import sd_spi_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  addr,
    input  logic [15:0] wdata,
    output logic        ack,
    output logic [15:0] rdata,
    output logic        spi_select,
    output logic [2:0]  spi_addr,
    output logic        spi_read_n,
    output logic        spi_write_n,
    output logic [15:0] spi_wdata,
    input  logic [15:0] spi_rdata
);

    bus_phase_e  phase_q, phase_d;
    logic        sel_q, sel_d;
    logic [2:0]  addr_q, addr_d;
    logic        rd_n_q, rd_n_d;
    logic        wr_n_q, wr_n_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rdata_q, rdata_d;

    always_comb begin
        phase_d = phase_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        rd_n_d  = rd_n_q;
        wr_n_d  = wr_n_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (phase_q)
            PH_IDLE: begin
                if (req) begin
                    sel_d   = 1'b1;
                    addr_d  = addr;
                    wdata_d = we ? wdata : 16'h0000;
                    rd_n_d  = we;
                    wr_n_d  = ~we;
                    phase_d = PH_ACC1;
                end
            end
            PH_ACC1: phase_d = PH_ACC2;
            PH_ACC2: begin
                // The core presents read data by the end of the second select cycle.
                rdata_d = spi_rdata;
                sel_d   = 1'b0;
                addr_d  = 3'd0;
                wdata_d = 16'h0000;
                rd_n_d  = 1'b1;
                wr_n_d  = 1'b1;
                phase_d = PH_GAP;
            end
            PH_GAP:  phase_d = PH_IDLE;
            default: phase_d = PH_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q <= PH_IDLE;
            sel_q   <= 1'b0;
            addr_q  <= 3'd0;
            rd_n_q  <= 1'b1;
            wr_n_q  <= 1'b1;
            wdata_q <= 16'h0000;
            rdata_q <= 16'h0000;
        end else begin
            phase_q <= phase_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            rd_n_q  <= rd_n_d;
            wr_n_q  <= wr_n_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign ack         = (phase_q == PH_GAP);
    assign rdata       = rdata_q;
    assign spi_select  = sel_q;
    assign spi_addr    = addr_q;
    assign spi_read_n  = rd_n_q;
    assign spi_write_n = wr_n_q;
    assign spi_wdata   = wdata_q;

endmodule

// File: rtl/sd_spi_xfer_seq.sv
// rtl/sd_spi_xfer_seq.sv - streams an N-byte burst through the SPI core; SD_SPI_SEQ_TIMEOUT_EN adds a poll timeout
module sd_spi_xfer_seq
    import sd_spi_pkg::*;
#(
    parameter int         LEN_W     = 10,
    parameter logic [7:0] FILL_BYTE = 8'hFF
`ifdef SD_SPI_SEQ_TIMEOUT_EN
    ,
    parameter int         TIMEOUT_CYCLES = 4096
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             tx_use_stream,
    input  logic             keep_ss,
    input  logic [7:0]       tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             spi_select,
    output logic [2:0]       spi_addr,
    output logic             spi_read_n,
    output logic             spi_write_n,
    output logic [15:0]      spi_wdata,
    input  logic [15:0]      spi_rdata
);

    seq_state_e       state_q, state_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             use_stream_q, use_stream_d;
    logic             keep_ss_q, keep_ss_d;
    logic             err_q, err_d;
    logic [7:0]       tx_byte_q, tx_byte_d;
    logic [7:0]       rx_byte_q, rx_byte_d;

    logic             bus_req, bus_we, bus_ack;
    logic [2:0]       bus_addr;
    logic [15:0]      bus_wdata, bus_rdata;
    logic             stat_rrdy, stat_fault, unused_rdata;

`ifdef SD_SPI_SEQ_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] POLL_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] poll_cnt_q, poll_cnt_d;
`endif

    assign stat_rrdy    = bus_rdata[STAT_RRDY];
    assign stat_fault   = bus_rdata[STAT_TOE] | bus_rdata[STAT_ROE];
    assign unused_rdata = ^bus_rdata[15:9];

    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        use_stream_d = use_stream_q;
        keep_ss_d    = keep_ss_q;
        err_d        = err_q;
        tx_byte_d    = tx_byte_q;
        rx_byte_d    = rx_byte_q;
        bus_req      = 1'b0;
        bus_we       = 1'b0;
        bus_addr     = REG_RXDATA;
        bus_wdata    = 16'h0000;
`ifdef SD_SPI_SEQ_TIMEOUT_EN
        poll_cnt_d   = poll_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    err_d = 1'b0;
                    if (len == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        rem_d        = len;
                        use_stream_d = tx_use_stream;
                        keep_ss_d    = keep_ss;
                        state_d      = ST_SS_ON;
                    end
                end
            end
            ST_SS_ON: begin
                bus_req   = 1'b1;
                bus_we    = 1'b1;
                bus_addr  = REG_CONTROL;
                bus_wdata = CTRL_SSO;
                if (bus_ack) state_d = ST_GET_TX;
            end
            ST_GET_TX: begin
                if (!use_stream_q) begin
                    tx_byte_d = FILL_BYTE;
                    state_d   = ST_WR_TX;
                end else if (tx_valid) begin
                    tx_byte_d = tx_data;
                    state_d   = ST_WR_TX;
                end
            end
            ST_WR_TX: begin
                bus_req   = 1'b1;
                bus_we    = 1'b1;
                bus_addr  = REG_TXDATA;
                bus_wdata = {8'h00, tx_byte_q};
`ifdef SD_SPI_SEQ_TIMEOUT_EN
                poll_cnt_d = '0;
`endif
                if (bus_ack) state_d = ST_POLL;
            end
            ST_POLL: begin
                bus_req  = 1'b1;
                bus_addr = REG_STATUS;
                if (bus_ack) begin
                    // A fault means another master touched the core mid-byte; abandon the burst.
                    if (stat_fault) begin
                        state_d = ST_ERR_CLR;
                    end else if (stat_rrdy) begin
                        state_d = ST_RD_RX;
                    end
`ifdef SD_SPI_SEQ_TIMEOUT_EN
                    else if (poll_cnt_q == POLL_LAST) begin
                        err_d   = 1'b1;
                        state_d = ST_ERR_CLR;
                    end else begin
                        poll_cnt_d = poll_cnt_q + 1'b1;
                    end
`endif
                end
            end
            ST_RD_RX: begin
                bus_req  = 1'b1;
                bus_addr = REG_RXDATA;
                if (bus_ack) begin
                    rx_byte_d = bus_rdata[7:0];
                    state_d   = ST_PUT_RX;
                end
            end
            ST_PUT_RX: begin
                if (rx_ready) begin
                    rem_d   = rem_q - 1'b1;
                    state_d = (rem_q == LEN_W'(1)) ? ST_SS_OFF : ST_GET_TX;
                end
            end
            ST_ERR_CLR: begin
                bus_req  = 1'b1;
                bus_we   = 1'b1;
                bus_addr = REG_STATUS;
                if (bus_ack) begin
                    err_d   = 1'b1;
                    state_d = ST_SS_OFF;
                end
            end
            ST_SS_OFF: begin
                if (keep_ss_q && !err_q) begin
                    state_d = ST_DONE;
                end else begin
                    bus_req  = 1'b1;
                    bus_we   = 1'b1;
                    bus_addr = REG_CONTROL;
                    if (bus_ack) state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            rem_q        <= '0;
            use_stream_q <= 1'b0;
            keep_ss_q    <= 1'b0;
            err_q        <= 1'b0;
            tx_byte_q    <= 8'h00;
            rx_byte_q    <= 8'h00;
`ifdef SD_SPI_SEQ_TIMEOUT_EN
            poll_cnt_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            rem_q        <= rem_d;
            use_stream_q <= use_stream_d;
            keep_ss_q    <= keep_ss_d;
            err_q        <= err_d;
            tx_byte_q    <= tx_byte_d;
            rx_byte_q    <= rx_byte_d;
`ifdef SD_SPI_SEQ_TIMEOUT_EN
            poll_cnt_q   <= poll_cnt_d;
`endif
        end
    end

    assign tx_ready = (state_q == ST_GET_TX) && use_stream_q;
    assign rx_valid = (state_q == ST_PUT_RX);
    assign rx_data  = rx_byte_q;
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign err      = err_q;

    sd_spi_bus_access u_bus (
        .clk         (clk),
        .reset       (reset),
        .req         (bus_req),
        .we          (bus_we),
        .addr        (bus_addr),
        .wdata       (bus_wdata),
        .ack         (bus_ack),
        .rdata       (bus_rdata),
        .spi_select  (spi_select),
        .spi_addr    (spi_addr),
        .spi_read_n  (spi_read_n),
        .spi_write_n (spi_write_n),
        .spi_wdata   (spi_wdata),
        .spi_rdata   (spi_rdata)
    );

endmodule

// File: tb/tb_sd_spi_xfer_seq.sv
// tb/tb_sd_spi_xfer_seq.sv - bench for sd_spi_xfer_seq with a loopback SPI core register model
module tb_sd_spi_xfer_seq;

    localparam int LEN_W  = 10;
    localparam int BUDGET = 20000;
    localparam logic [19:0] TOK_STAT = {1'b0, 3'd2, 16'h0000};

    logic             clk = 1'b0;
    logic             reset, start, tx_use_stream, keep_ss;
    logic [LEN_W-1:0] len;
    logic [7:0]       tx_data, rx_data;
    logic             tx_valid, tx_ready, rx_valid, rx_ready;
    logic             busy, done, err;
    logic             spi_select, spi_read_n, spi_write_n;
    logic [2:0]       spi_addr;
    logic [15:0]      spi_wdata, spi_rdata;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sd_spi_xfer_seq #(
        .LEN_W(LEN_W),
        .FILL_BYTE(8'hFF)
`ifdef SD_SPI_SEQ_TIMEOUT_EN
        , .TIMEOUT_CYCLES(16)
`endif
    ) dut (
        .clk(clk), .reset(reset), .start(start), .len(len),
        .tx_use_stream(tx_use_stream), .keep_ss(keep_ss),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .busy(busy), .done(done), .err(err),
        .spi_select(spi_select), .spi_addr(spi_addr), .spi_read_n(spi_read_n),
        .spi_write_n(spi_write_n), .spi_wdata(spi_wdata), .spi_rdata(spi_rdata)
    );

    // SPI core model: MISO looped to MOSI, RRDY a few cycles after each TX write.
    logic [15:0] core_ctrl = 16'h0000;
    logic        core_rrdy = 1'b0, core_toe = 1'b0, core_roe = 1'b0;
    logic [7:0]  core_rx = 8'h00, core_shift = 8'h00;
    int          pend_cnt = 0, roe_at_write = -1, txw_count = 0;
    bit          core_never_rrdy = 0;
    int          sel_run = 0, sel_cycles = 0, proto_err = 0;
    logic        a_we;
    logic [2:0]  a_addr;
    logic [15:0] a_wd;
    logic [19:0] trace[$];
    logic [7:0]  tx_bytes[$];

    assign spi_rdata = (spi_addr == 3'd0) ? {8'h00, core_rx} :
                       (spi_addr == 3'd2) ? {7'b0, core_rrdy, 2'b0, core_toe, core_roe, 4'b0} :
                       (spi_addr == 3'd3) ? core_ctrl : 16'h0000;

    always @(posedge clk) begin
        if (reset) begin
            core_rrdy <= 1'b0; core_toe <= 1'b0; core_roe <= 1'b0;
            pend_cnt = 0; sel_run = 0;
        end else begin
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0 && !core_never_rrdy) begin
                    core_rrdy <= 1'b1;
                    core_rx   <= core_shift;
                end
            end
            if (spi_select) begin
                sel_cycles++;
                if (sel_run == 0) begin
                    a_we = !spi_write_n; a_addr = spi_addr; a_wd = spi_wdata;
                    if (spi_read_n == spi_write_n) proto_err++;
                end else if (a_we !== !spi_write_n || a_addr !== spi_addr || a_wd !== spi_wdata) begin
                    proto_err++;
                end
                sel_run++;
                if (sel_run == 2) begin
                    trace.push_back({a_we, a_addr, (a_we && a_addr != 3'd2) ? a_wd : 16'h0000});
                    if (a_we) begin
                        case (a_addr)
                            3'd1: begin
                                txw_count++;
                                core_shift = a_wd[7:0];
                                pend_cnt = $urandom_range(1, 6);
                                if (txw_count == roe_at_write) core_roe <= 1'b1;
                            end
                            3'd2: begin
                                core_rrdy <= 1'b0; core_toe <= 1'b0; core_roe <= 1'b0;
                                pend_cnt = 0;
                            end
                            3'd3: core_ctrl <= a_wd;
                            default: ;
                        endcase
                    end else if (a_addr == 3'd0) begin
                        core_rrdy <= 1'b0;
                    end
                end else if (sel_run > 2) begin
                    proto_err++;
                end
            end else begin
                sel_run = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // err_byte >= 0: the burst aborts while that byte is in flight (ROE injection or timeout).
    task automatic run_burst(input int n, input bit us, input bit kss, input int stall_at,
                             input int err_byte, input bit poke_start);
        logic [19:0] expq[$];
        logic [19:0] comp[$];
        logic [7:0]  expect_rx[$];
        logic [7:0]  got[$];
        int done_cnt, errs_before;
        bit finished, timed_out, bad_ready, stall_ok, stalled, exp_err;
        done_cnt = 0; finished = 0; timed_out = 0; bad_ready = 0; stall_ok = 1; stalled = 0;
        exp_err = (err_byte >= 0);
        errs_before = n_errors;

        expq.push_back({1'b1, 3'd3, 16'h0400});
        for (int i = 0; i < n; i++) begin
            logic [7:0] b;
            b = us ? tx_bytes[i] : 8'hFF;
            expq.push_back({1'b1, 3'd1, 8'h00, b});
            expq.push_back(TOK_STAT);
            if (exp_err && i == err_byte) begin
                expq.push_back({1'b1, 3'd2, 16'h0000});
                break;
            end
            expq.push_back({1'b0, 3'd0, 16'h0000});
            expect_rx.push_back(b);
        end
        if (!kss || exp_err) expq.push_back({1'b1, 3'd3, 16'h0000});

        roe_at_write = (exp_err && !core_never_rrdy) ? txw_count + err_byte + 1 : -1;
        trace.delete();

        @(negedge clk);
        len = LEN_W'(n); tx_use_stream = us; keep_ss = kss; start = 1'b1;
        @(negedge clk);
        start = 1'b0;

        fork
            begin
                int idx;
                idx = 0;
                while (!finished) begin
                    @(negedge clk);
                    if (!us && tx_ready) bad_ready = 1;
                    if (us && idx < n) begin
                        tx_valid = ($urandom_range(0, 3) != 0);
                        tx_data  = tx_bytes[idx];
                        if (tx_valid && tx_ready) idx++;
                    end else begin
                        tx_valid = 1'b0;
                    end
                end
                tx_valid = 1'b0;
            end
            begin
                while (!finished) begin
                    @(negedge clk);
                    if (stall_at >= 0 && !stalled && rx_valid && got.size() == stall_at) begin
                        logic [7:0] held;
                        int w;
                        stalled = 1; held = rx_data; w = txw_count; rx_ready = 1'b0;
                        repeat (200) begin
                            @(negedge clk);
                            if (rx_valid !== 1'b1 || rx_data !== held) stall_ok = 0;
                        end
                        if (txw_count != w) stall_ok = 0;
                    end
                    rx_ready = ($urandom_range(0, 2) != 0);
                    if (rx_valid && rx_ready) got.push_back(rx_data);
                end
                rx_ready = 1'b0;
            end
            begin
                for (int c = 0; c < BUDGET && !finished; c++) begin
                    @(negedge clk);
                    if (poke_start && c == 12) begin
                        start = 1'b1; len = LEN_W'(7);
                    end else begin
                        start = 1'b0;
                    end
                    if (done) done_cnt++;
                    if (!busy) finished = 1;
                end
                if (!finished) begin
                    timed_out = 1;
                    finished = 1;
                end
            end
        join
        roe_at_write = -1;

        foreach (trace[i])
            if (!(trace[i] == TOK_STAT && comp.size() > 0 && comp[$] == TOK_STAT))
                comp.push_back(trace[i]);

        chk("burst_timeout", timed_out, 0);
        chk("done_pulses", done_cnt, 1);
        chk("err_flag", err, exp_err);
        chk("bus_protocol", proto_err, 0);
        chk("sso_after", core_ctrl[10], kss && !exp_err);
        chk("rx_count", got.size(), expect_rx.size());
        if (got.size() == expect_rx.size())
            foreach (got[i]) chk("rx_byte", got[i], expect_rx[i]);
        chk("trace_len", comp.size(), expq.size());
        if (comp.size() == expq.size())
            foreach (comp[i]) chk("trace_tok", comp[i], expq[i]);
        if (!us) chk("fill_no_tx_ready", bad_ready, 0);
        if (stall_at >= 0) begin
            chk("stall_seen", stalled, 1);
            chk("stall_hold", stall_ok, 1);
        end
        if (n_errors != errs_before)
            $display("burst n=%0d us=%0d kss=%0d err_byte=%0d had failing checks", n, us, kss, err_byte);
    endtask

    initial begin
        int c, s0, polls;
        reset = 1'b1; start = 1'b0; len = '0; tx_use_stream = 1'b0; keep_ss = 1'b0;
        tx_data = 8'h00; tx_valid = 1'b0; rx_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_select", spi_select, 0);
        chk("rst_read_n", spi_read_n, 1);
        chk("rst_write_n", spi_write_n, 1);
        chk("rst_addr", spi_addr, 0);
        chk("rst_wdata", spi_wdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_tx_ready", tx_ready, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_data", rx_data, 0);

        tx_bytes = '{8'hA5, 8'h3C, 8'hFF};
        run_burst(3, 1'b1, 1'b0, -1, -1, 1'b1);

        s0 = sel_cycles;
        @(negedge clk);
        len = '0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("len0_done", done, 1);
        chk("len0_busy", busy, 1);
        @(negedge clk);
        chk("len0_done_end", done, 0);
        chk("len0_busy_end", busy, 0);
        repeat (3) @(negedge clk);
        chk("len0_no_bus", sel_cycles, s0);

        run_burst(2, 1'b0, 1'b1, -1, -1, 1'b0);

        tx_bytes.delete();
        for (int i = 0; i < 4; i++) tx_bytes.push_back(8'($urandom));
        run_burst(4, 1'b1, 1'b0, -1, 1, 1'b0);

        tx_bytes.delete();
        for (int i = 0; i < 3; i++) tx_bytes.push_back(8'($urandom));
        run_burst(3, 1'b1, 1'b0, 0, -1, 1'b0);

        for (int r = 0; r < 6; r++) begin
            int n;
            n = $urandom_range(1, 12);
            tx_bytes.delete();
            for (int i = 0; i < n; i++) tx_bytes.push_back(8'($urandom));
            run_burst(n, 1'($urandom), 1'($urandom), -1, -1, 1'b0);
        end

`ifdef SD_SPI_SEQ_TIMEOUT_EN
        core_never_rrdy = 1;
        run_burst(2, 1'b0, 1'b0, -1, 0, 1'b0);
        core_never_rrdy = 0;
        polls = 0;
        foreach (trace[i]) if (trace[i] == TOK_STAT) polls++;
        chk("timeout_polls", polls, 16);
`endif

        @(negedge clk);
        len = LEN_W'(6); tx_use_stream = 1'b0; keep_ss = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0; rx_ready = 1'b1;
        c = 0;
        while (c < 200 && !(c >= 20 && spi_select === 1'b1)) begin
            @(negedge clk);
            c++;
        end
        chk("rst_mid_access", spi_select, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_select", spi_select, 0);
        chk("rst_mid_read_n", spi_read_n, 1);
        chk("rst_mid_write_n", spi_write_n, 1);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_rx_valid", rx_valid, 0);
        reset = 1'b0; rx_ready = 1'b0;

        tx_bytes.delete();
        for (int i = 0; i < 5; i++) tx_bytes.push_back(8'($urandom));
        run_burst(5, 1'b1, 1'b0, -1, -1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
